// File: rtl/volt_pkg.sv
// Shared types and constants for the voltmeter measurement controller.
// Declarations only: no logic, no latency, no flow control.
package volt_pkg;
    localparam int ADC_W          = 8;
    localparam int VOLT_W         = 16;
    localparam int MV_PER_LSB_DEF = 39;

    typedef enum logic [1:0] {
        CAL  = 2'd0,
        ACQ  = 2'd1,
        CONV = 2'd2,
        OUT  = 2'd3
    } state_t;
endpackage

// File: rtl/volt_meas_ctrl_if.sv
// ADC-side inputs and display-side results of the measurement controller.
// Plain wires; timing and pulse semantics are owned by volt_meas_ctrl.
interface volt_meas_ctrl_if;
    logic [volt_pkg::ADC_W-1:0]  ad_data;
    logic                        hold;
    logic                        recal;
    logic                        ad_clk;
    logic [volt_pkg::VOLT_W-1:0] volt;
    logic                        sign;
    logic                        volt_vld;
    logic                        cal_done;

    modport master (
        output ad_data, hold, recal,
        input  ad_clk, volt, sign, volt_vld, cal_done
    );

    modport slave (
        input  ad_data, hold, recal,
        output ad_clk, volt, sign, volt_vld, cal_done
    );
endinterface

// File: rtl/adc_avg.sv
// ADC sample clock generator and 2^AVG_LOG2-sample averager; avg/avg_vld are combinational on the last sample strobe.
// No backpressure: every strobe is consumed, clr drops the running sum and any strobe in the same cycle.
module adc_avg
    import volt_pkg::*;
#(
    parameter int CLK_DIV  = 50,
    parameter int AVG_LOG2 = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [ADC_W-1:0] ad_data,
    output logic             ad_clk,
    output logic [ADC_W-1:0] avg,
    output logic             avg_vld
);
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                ad_clk_q, ad_clk_d;
    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic [AVG_LOG2-1:0] n_cnt_q, n_cnt_d;
    logic                smp, last;

    always_comb begin
        smp       = (div_cnt_q == DIV_LAST);
        div_cnt_d = smp ? '0 : div_cnt_q + 1'b1;
        ad_clk_d  = (div_cnt_q >= DIV_HALF);
        acc_sum   = acc_q + ACC_W'(ad_data);
        last      = &n_cnt_q;
        avg       = acc_sum[ACC_W-1:AVG_LOG2];
        avg_vld   = smp && last && !clr;
        acc_d     = acc_q;
        n_cnt_d   = n_cnt_q;
        // The divider keeps running through clr so the sample grid never shifts.
        if (clr) begin
            acc_d   = '0;
            n_cnt_d = '0;
        end else if (smp) begin
            acc_d   = last ? '0 : acc_sum;
            n_cnt_d = n_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            ad_clk_q  <= 1'b0;
            acc_q     <= '0;
            n_cnt_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ad_clk_q  <= ad_clk_d;
            acc_q     <= acc_d;
            n_cnt_q   <= n_cnt_d;
        end
    end

    assign ad_clk = ad_clk_q;
endmodule

// File: rtl/volt_meas_ctrl.sv
// Voltmeter sequencer: offset calibration, averaging, mV conversion; result 2 cycles after the last sample of an average.
// No backpressure: hold only suppresses the output update, acquisition never stalls.
module volt_meas_ctrl
    import volt_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int AVG_LOG2   = 10,
    parameter int MV_PER_LSB = MV_PER_LSB_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    volt_meas_ctrl_if.slave  bus
);
    localparam logic [VOLT_W-1:0] MV_K = VOLT_W'(MV_PER_LSB);

    logic [ADC_W-1:0]  avg;
    logic              avg_vld;
    state_t            state_q;
    logic [ADC_W-1:0]  offset_q, avg_q;
    logic [VOLT_W-1:0] mag_mv_q, volt_q;
    logic              neg_q, sign_q, volt_vld_q, cal_done_q;
    logic [ADC_W:0]    diff, mag;
    logic [VOLT_W-1:0] mag_mv;
    logic              neg;

    adc_avg #(
        .CLK_DIV  (CLK_DIV),
        .AVG_LOG2 (AVG_LOG2)
    ) u_adc_avg (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .clr     (bus.recal),
        .ad_data (bus.ad_data),
        .ad_clk  (bus.ad_clk),
        .avg     (avg),
        .avg_vld (avg_vld)
    );

    // 9-bit two's complement difference; magnitude never exceeds 255.
    always_comb begin
        diff   = {1'b0, avg_q} - {1'b0, offset_q};
        neg    = diff[ADC_W];
        mag    = neg ? (~diff + 1'b1) : diff;
        mag_mv = VOLT_W'(mag) * MV_K;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= CAL;
            offset_q   <= '0;
            avg_q      <= '0;
            mag_mv_q   <= '0;
            neg_q      <= 1'b0;
            volt_q     <= '0;
            sign_q     <= 1'b0;
            volt_vld_q <= 1'b0;
            cal_done_q <= 1'b0;
        end else begin
            volt_vld_q <= 1'b0;
            if (bus.recal) begin
                state_q    <= CAL;
                cal_done_q <= 1'b0;
            end else begin
                case (state_q)
                    CAL: if (avg_vld) begin
                        offset_q   <= avg;
                        cal_done_q <= 1'b1;
                        state_q    <= ACQ;
                    end
                    ACQ: if (avg_vld) begin
                        avg_q   <= avg;
                        state_q <= CONV;
                    end
                    CONV: begin
                        mag_mv_q <= mag_mv;
                        neg_q    <= neg && (mag != '0);
                        state_q  <= OUT;
                    end
                    OUT: begin
                        if (!bus.hold) begin
                            volt_q     <= mag_mv_q;
                            sign_q     <= neg_q;
                            volt_vld_q <= 1'b1;
                        end
                        state_q <= ACQ;
                    end
                    default: state_q <= CAL;
                endcase
            end
        end
    end

    assign bus.volt     = volt_q;
    assign bus.sign     = sign_q;
    assign bus.volt_vld = volt_vld_q;
    assign bus.cal_done = cal_done_q;
endmodule

// File: tb/tb_volt_meas_ctrl.sv
// Bench for volt_meas_ctrl with CLK_DIV=4, AVG_LOG2=2: constant vectors, hand sequences,
// and a random run, all cross-checked every cycle against a sample-level reference model.
module tb_volt_meas_ctrl;
    localparam int NS  = 4;   // samples per average
    localparam int DIV = 4;   // clocks per sample
    localparam int K   = 39;  // mV per LSB

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    volt_meas_ctrl_if bus();

    volt_meas_ctrl #(
        .CLK_DIV    (DIV),
        .AVG_LOG2   (2),
        .MV_PER_LSB (K)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Reference model: sample phase, window of collected samples, one pending result.
    int m_phase = 0;
    int m_cyc   = 0;
    bit m_cal   = 0;
    int m_offset = 0;
    int m_win[$];
    bit m_pend = 0;
    int m_due = 0;
    int m_pmv = 0;
    bit m_pneg = 0;
    int m_volt = 0;
    bit m_sign = 0;
    bit m_vld  = 0;

    typedef struct {
        int off;
        int meas;
        int exp_volt;
        bit exp_sign;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit smp_e;
        int sum, avg, diff, mag;
        m_cyc++;
        m_vld = 0;
        if (!rst_n) begin
            m_phase = 0; m_cal = 0; m_offset = 0; m_win.delete();
            m_pend = 0; m_volt = 0; m_sign = 0;
            return;
        end
        smp_e   = (m_phase == DIV - 1);
        m_phase = (m_phase + 1) % DIV;
        if (bus.recal) begin
            m_cal = 0; m_win.delete(); m_pend = 0;
            return;
        end
        if (m_pend && m_cyc == m_due) begin
            m_pend = 0;
            if (!bus.hold) begin
                m_volt = m_pmv; m_sign = m_pneg; m_vld = 1;
            end
        end
        if (smp_e) begin
            m_win.push_back(int'(bus.ad_data));
            if (m_win.size() == NS) begin
                sum = 0;
                foreach (m_win[i]) sum += m_win[i];
                avg = sum / NS;
                m_win.delete();
                if (!m_cal) begin
                    m_offset = avg; m_cal = 1;
                end else begin
                    diff   = avg - m_offset;
                    mag    = (diff < 0) ? -diff : diff;
                    m_pmv  = (mag * K) % 65536;
                    m_pneg = (diff < 0);
                    m_pend = 1;
                    m_due  = m_cyc + 2;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("cyc_volt",     32'(bus.volt),     32'(m_volt));
        chk("cyc_sign",     32'(bus.sign),     32'(m_sign));
        chk("cyc_volt_vld", 32'(bus.volt_vld), 32'(m_vld));
        chk("cyc_cal_done", 32'(bus.cal_done), 32'(m_cal));
    endtask

    // Hold d until exactly one sample strobe has passed.
    task automatic sample(input int d);
        bus.ad_data = 8'(d);
        do tick(); while (m_phase != 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_vld(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = (bus.volt_vld === 1'b1);
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: volt_vld not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic run_count(input int cycles, output int n_vld, output int n_hi);
        n_vld = 0;
        n_hi  = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.volt_vld === 1'b1) n_vld++;
            if (bus.ad_clk === 1'b1) n_hi++;
        end
    endtask

    initial begin
        int nv, nh;
        vecs[0] = '{128, 128,    0, 1'b0};
        vecs[1] = '{128, 255, 4953, 1'b0};
        vecs[2] = '{128,   0, 4992, 1'b1};
        vecs[3] = '{100, 100,    0, 1'b0};
        vecs[4] = '{  0, 255, 9945, 1'b0};
        vecs[5] = '{255,   0, 9945, 1'b1};
        vecs[6] = '{128, 129,   39, 1'b0};
        vecs[7] = '{128, 127,   39, 1'b1};

        rst_n = 1'b0; bus.ad_data = '0; bus.hold = 1'b0; bus.recal = 1'b0;
        do_reset();
        chk("rst_ad_clk", 32'(bus.ad_clk), 0);
        chk("rst_volt", 32'(bus.volt), 0);

        foreach (vecs[v]) begin
            do_reset();
            repeat (NS) sample(vecs[v].off);
            chk($sformatf("vec%0d_cal_done", v), 32'(bus.cal_done), 1);
            repeat (NS) sample(vecs[v].meas);
            wait_vld($sformatf("vec%0d_vld", v), 6);
            chk($sformatf("vec%0d_volt", v), 32'(bus.volt), 32'(vecs[v].exp_volt));
            chk($sformatf("vec%0d_sign", v), 32'(bus.sign), 32'(vecs[v].exp_sign));
        end

        // Calibration timing, then consecutive results without recalibrating.
        do_reset();
        repeat (NS - 1) sample(128);
        chk("cal_not_yet", 32'(bus.cal_done), 0);
        sample(128);
        chk("cal_after_4", 32'(bus.cal_done), 1);
        repeat (NS) sample(255);
        wait_vld("pos_vld", 6);
        chk("pos_volt", 32'(bus.volt), 4953);
        chk("pos_sign", 32'(bus.sign), 0);
        repeat (NS) sample(0);
        wait_vld("neg_vld", 6);
        chk("neg_volt", 32'(bus.volt), 4992);
        chk("neg_sign", 32'(bus.sign), 1);
        sample(120); sample(130); sample(140); sample(150);
        wait_vld("mix_vld", 6);
        chk("mix_volt", 32'(bus.volt), 273);
        chk("mix_sign", 32'(bus.sign), 0);
        bus.ad_data = 8'd135;
        run_count(32, nv, nh);
        chk("steady_vld_count", 32'(nv), 2);
        chk("ad_clk_duty", 32'(nh), 16);

        // hold freezes outputs while acquisition keeps running.
        bus.hold = 1'b1;
        bus.ad_data = 8'd200;
        run_count(40, nv, nh);
        chk("hold_no_pulse", 32'(nv), 0);
        chk("hold_volt", 32'(bus.volt), 273);
        chk("hold_sign", 32'(bus.sign), 0);
        bus.hold = 1'b0;
        wait_vld("unhold_vld", 20);
        chk("unhold_volt", 32'(bus.volt), 2808);

        // recal coincident with a sample strobe drops that sample.
        bus.ad_data = 8'd100;
        for (int i = 0; i < DIV && m_phase != DIV - 1; i++) tick();
        bus.recal = 1'b1;
        tick();
        bus.recal = 1'b0;
        chk("recal_cal_done", 32'(bus.cal_done), 0);
        repeat (NS - 1) sample(100);
        chk("recal_cal_not_yet", 32'(bus.cal_done), 0);
        sample(100);
        chk("recal_cal_done_again", 32'(bus.cal_done), 1);
        chk("recal_volt_held", 32'(bus.volt), 2808);
        repeat (NS) sample(100);
        wait_vld("recal_vld", 6);
        chk("recal_volt", 32'(bus.volt), 0);
        chk("recal_sign", 32'(bus.sign), 0);

        // One-cycle reset in the middle of an average.
        repeat (2) sample(50);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_volt", 32'(bus.volt), 0);
        chk("mid_rst_vld", 32'(bus.volt_vld), 0);
        chk("mid_rst_cal", 32'(bus.cal_done), 0);
        chk("mid_rst_ad_clk", 32'(bus.ad_clk), 0);
        repeat (NS - 1) sample(60);
        chk("mid_rst_cal_not_yet", 32'(bus.cal_done), 0);
        sample(60);
        chk("mid_rst_cal_back", 32'(bus.cal_done), 1);

        // Random data with occasional hold toggles and recal pulses at any phase.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 15) == 0) bus.hold = ~bus.hold;
            if ($urandom_range(0, 23) == 0) begin
                bus.recal = 1'b1;
                tick();
                bus.recal = 1'b0;
            end
            sample(($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 146))
                                               : int'($urandom_range(0, 255)));
        end
        bus.hold = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
